// File: rtl/mem_tile_sequencer_pkg.sv
// Shared types and constants for the memory tile sequencer and its read FIFO.
package mem_tile_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_e;

    localparam int         FIFO_DEPTH = 2;
    localparam logic [4:0] MAX_BYTES  = 5'd16;

    // Rows wider than the memory port are clipped to the port width.
    function automatic logic [4:0] eff_bytes(input logic [4:0] b);
        return (b > MAX_BYTES) ? MAX_BYTES : b;
    endfunction

endpackage

// File: rtl/seq_fifo2.sv
// Two-entry row FIFO between memory read returns and the read stream.
module seq_fifo2
    import mem_tile_sequencer_pkg::*;
#(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Storage is not reset; the head is gated so an empty FIFO presents zeros.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign valid_o = (count_q != 2'd0);
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/mem_tile_sequencer.sv
// Walks a strided tile of rows, streaming writes into memory or reads out of it.
module mem_tile_sequencer
    import mem_tile_sequencer_pkg::*;
#(
    parameter int NUM_RAMS = 16,
    parameter int D_WID    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_start,
    input  logic                      cfg_rdwr,
    input  logic [31:0]               cfg_base,
    input  logic [31:0]               cfg_stride,
    input  logic [7:0]                cfg_rows,
    input  logic [4:0]                cfg_bytes,
    output logic                      busy,
    output logic                      done,
    output logic                      interface_en,
    output logic                      interface_rdwr,
    output logic [4:0]                interface_control,
    output logic [31:0]               interface_addr,
    output logic [NUM_RAMS*D_WID-1:0] interface_wr_data,
    input  logic [NUM_RAMS*D_WID-1:0] interface_rd_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [NUM_RAMS*D_WID-1:0] wr_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic [NUM_RAMS*D_WID-1:0] rd_data
);

    localparam int DW = NUM_RAMS * D_WID;

    seq_state_e   state_q;
    logic         rdwr_q;
    logic [31:0]  addr_q;
    logic [31:0]  addr_d;
    logic [31:0]  stride_q;
    logic [7:0]   rows_left_q;
    logic [4:0]   bytes_q;
    logic         inflight_q;

    logic         in_run;
    logic         last_row;
    logic         wr_accept;
    logic         rd_issue;
    logic [1:0]   fifo_count;
    logic [DW-1:0] rd_masked;

    function automatic logic [DW-1:0] mask_row(input logic [DW-1:0] d, input logic [4:0] n);
        logic [DW-1:0] m;
        m = d;
        for (int i = 0; i < NUM_RAMS; i++) begin
            if (i >= int'(n)) m[i*D_WID +: D_WID] = '0;
        end
        return m;
    endfunction

    assign in_run    = (state_q == ST_RUN);
    assign last_row  = (rows_left_q == 8'd1);
    assign wr_ready  = in_run && rdwr_q && (rows_left_q != 8'd0);
    assign wr_accept = wr_ready && wr_valid;
    // Throttle so a returning read always has a FIFO slot waiting for it.
    assign rd_issue  = in_run && !rdwr_q && (rows_left_q != 8'd0) &&
                       (({1'b0, fifo_count} + {2'b0, inflight_q}) < 3'(FIFO_DEPTH));
    assign addr_d    = addr_q + stride_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rdwr_q      <= 1'b0;
            addr_q      <= '0;
            stride_q    <= '0;
            rows_left_q <= '0;
            bytes_q     <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= rd_issue;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start) begin
                        rdwr_q      <= cfg_rdwr;
                        addr_q      <= cfg_base;
                        stride_q    <= cfg_stride;
                        rows_left_q <= cfg_rows;
                        bytes_q     <= eff_bytes(cfg_bytes);
                        state_q     <= (cfg_rows == 8'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (wr_accept || rd_issue) begin
                        addr_q      <= addr_d;
                        rows_left_q <= rows_left_q - 8'd1;
                        if (last_row) state_q <= rdwr_q ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!inflight_q && (fifo_count == 2'd0)) state_q <= ST_DONE;
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy              = in_run || (state_q == ST_DRAIN);
    assign done              = (state_q == ST_DONE);
    assign interface_en      = wr_accept || rd_issue;
    assign interface_rdwr    = wr_accept;
    assign interface_control = in_run ? bytes_q : 5'd0;
    assign interface_addr    = in_run ? addr_q : 32'd0;
    assign interface_wr_data = wr_accept ? wr_data : '0;

    assign rd_masked = mask_row(interface_rd_data, bytes_q);

    seq_fifo2 #(
        .W (DW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (inflight_q),
        .din_i   (rd_masked),
        .pop_i   (rd_ready),
        .dout_o  (rd_data),
        .valid_o (rd_valid),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_mem_tile_sequencer.sv
// Directed bench for mem_tile_sequencer with a one-cycle-latency memory responder.
module tb_mem_tile_sequencer;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cfg_start = 1'b0;
    logic         cfg_rdwr = 1'b0;
    logic [31:0]  cfg_base = '0;
    logic [31:0]  cfg_stride = '0;
    logic [7:0]   cfg_rows = '0;
    logic [4:0]   cfg_bytes = '0;
    logic         busy, done, interface_en, interface_rdwr;
    logic [4:0]   interface_control;
    logic [31:0]  interface_addr;
    logic [127:0] interface_wr_data;
    logic [127:0] interface_rd_data = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [127:0] wr_data = '0;
    logic         rd_valid;
    logic         rd_ready = 1'b0;
    logic [127:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0]  exp_addr [8];
    logic [127:0] exp_row  [8];
    logic [127:0] pend;

    mem_tile_sequencer dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_start         (cfg_start),
        .cfg_rdwr          (cfg_rdwr),
        .cfg_base          (cfg_base),
        .cfg_stride        (cfg_stride),
        .cfg_rows          (cfg_rows),
        .cfg_bytes         (cfg_bytes),
        .busy              (busy),
        .done              (done),
        .interface_en      (interface_en),
        .interface_rdwr    (interface_rdwr),
        .interface_control (interface_control),
        .interface_addr    (interface_addr),
        .interface_wr_data (interface_wr_data),
        .interface_rd_data (interface_rd_data),
        .wr_valid          (wr_valid),
        .wr_ready          (wr_ready),
        .wr_data           (wr_data),
        .rd_valid          (rd_valid),
        .rd_ready          (rd_ready),
        .rd_data           (rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] pat(input logic [31:0] a);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = a[7:0] + 8'(i + 1);
        return r;
    endfunction

    function automatic logic [127:0] wrow(input int k);
        return {16{8'(8'hA0 + k)}};
    endfunction

    // Memory answers one cycle after an issued read; otherwise it returns filler.
    always @(negedge clk) pend <= (interface_en && !interface_rdwr) ? pat(interface_addr) : {16{8'hEE}};
    always @(posedge clk) interface_rd_data <= pend;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_ready"}, wr_ready, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_en"}, interface_en, 0);
        check({tag, "_rdwr"}, interface_rdwr, 0);
        check({tag, "_ctrl"}, interface_control, 0);
        check({tag, "_addr"}, interface_addr, 0);
        check({tag, "_wdata"}, interface_wr_data, 0);
        check({tag, "_rdata"}, rd_data, 0);
    endtask

    task automatic run_write(input logic [31:0] base, input logic [31:0] stride, input logic [7:0] rows,
                             input logic [4:0] bytes, input logic [4:0] exp_ctrl);
        @(posedge clk); #1;
        cfg_rdwr = 1'b1; cfg_base = base; cfg_stride = stride; cfg_rows = rows; cfg_bytes = bytes;
        cfg_start = 1'b1; wr_valid = 1'b1; wr_data = wrow(0);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        for (int k = 0; k < int'(rows); k++) begin
            @(negedge clk);
            check("wr_en", interface_en, 1);
            check("wr_rdwr", interface_rdwr, 1);
            check("wr_ready", wr_ready, 1);
            check("wr_addr", interface_addr, exp_addr[k]);
            check("wr_ctrl", interface_control, exp_ctrl);
            check("wr_data", interface_wr_data, wrow(k));
            check("wr_busy", busy, 1);
            @(posedge clk); #1;
            wr_data = wrow(k + 1);
            if (k == int'(rows) - 1) wr_valid = 1'b0;
        end
        @(negedge clk);
        check("wr_done", done, 1);
        check("wr_done_busy", busy, 0);
        check("wr_done_en", interface_en, 0);
        check("wr_done_ready", wr_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("wr_done_pulse", done, 0);
    endtask

    task automatic run_read(input logic [31:0] base, input logic [31:0] stride, input logic [7:0] rows,
                            input logic [4:0] bytes, input logic [4:0] exp_ctrl, input bit alt, input bit glitch);
        int  iss;
        int  pops;
        bit  seen_done;
        iss = 0; pops = 0; seen_done = 0;
        @(posedge clk); #1;
        cfg_rdwr = 1'b0; cfg_base = base; cfg_stride = stride; cfg_rows = rows; cfg_bytes = bytes;
        cfg_start = 1'b1; rd_ready = alt ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        if (glitch) begin
            cfg_base = 32'hDEAD0000; cfg_rows = 8'd1; cfg_rdwr = 1'b1;
        end
        for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
            @(negedge clk);
            if (interface_en) begin
                check("rd_rdwr", interface_rdwr, 0);
                check("rd_outstanding", (iss - pops) < 2, 1);
                check("rd_addr", interface_addr, (iss < 8) ? exp_addr[iss] : 32'hFFFF_FFFF);
                check("rd_ctrl", interface_control, exp_ctrl);
                iss++;
            end
            if (rd_valid && rd_ready) begin
                check("rd_row", rd_data, (pops < 8) ? exp_row[pops] : '1);
                pops++;
            end
            if (done) begin
                seen_done = 1;
                check("rd_done_pops", pops, rows);
                check("rd_done_issues", iss, rows);
            end else begin
                check("rd_busy", busy, 1);
            end
            @(posedge clk); #1;
            if (alt) rd_ready = ~rd_ready;
            cfg_start = glitch && (cyc >= 1) && (cyc < 4);
        end
        cfg_start = 1'b0;
        check("rd_done_seen", seen_done, 1);
        @(negedge clk);
        check("rd_after_done", done, 0);
        check("rd_after_busy", busy, 0);
    endtask

    initial begin
        #3 rst = 1'b1;
        #1 check_zero("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Three full-width writes on consecutive cycles.
        exp_addr[0] = 32'h100; exp_addr[1] = 32'h120; exp_addr[2] = 32'h140;
        run_write(32'h100, 32'h20, 8'd3, 5'd16, 5'd16);

        // Four 5-byte reads; upper bytes must come back zeroed.
        exp_addr[0] = 32'h07; exp_addr[1] = 32'h1A; exp_addr[2] = 32'h2D; exp_addr[3] = 32'h40;
        exp_row[0] = 128'h0C0B0A0908;
        exp_row[1] = 128'h1F1E1D1C1B;
        exp_row[2] = 128'h3231302F2E;
        exp_row[3] = 128'h4544434241;
        run_read(32'h7, 32'h13, 8'd4, 5'd5, 5'd5, 1'b0, 1'b0);

        // Alternating rd_ready, oversized byte count, and a start pulse while busy.
        exp_addr[0] = 32'h80; exp_addr[1] = 32'h90; exp_addr[2] = 32'hA0; exp_addr[3] = 32'hB0;
        exp_row[0] = 128'h908F8E8D8C8B8A898887868584838281;
        exp_row[1] = 128'hA09F9E9D9C9B9A999897969594939291;
        exp_row[2] = 128'hB0AFAEADACABAAA9A8A7A6A5A4A3A2A1;
        exp_row[3] = 128'hC0BFBEBDBCBBBAB9B8B7B6B5B4B3B2B1;
        run_read(32'h80, 32'h10, 8'd4, 5'd20, 5'd16, 1'b1, 1'b1);

        // Zero rows: straight to DONE without touching memory.
        @(posedge clk); #1;
        cfg_rdwr = 1'b0; cfg_rows = 8'd0; cfg_bytes = 5'd20; cfg_start = 1'b1;
        @(negedge clk);
        check("zero_en_start", interface_en, 0);
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("zero_done", done, 1);
        check("zero_en", interface_en, 0);
        check("zero_busy", busy, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done_pulse", done, 0);

        // Address accumulator wraps modulo 2^32.
        exp_addr[0] = 32'hFFFF_FFF0; exp_addr[1] = 32'h0000_0000;
        run_write(32'hFFFF_FFF0, 32'h10, 8'd2, 5'd9, 5'd9);

        // Reset during the second row of a five-row read.
        @(posedge clk); #1;
        cfg_rdwr = 1'b0; cfg_base = 32'h200; cfg_stride = 32'h4; cfg_rows = 8'd5; cfg_bytes = 5'd16;
        cfg_start = 1'b1; rd_ready = 1'b0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("rst_row0_en", interface_en, 1);
        check("rst_row0_addr", interface_addr, 32'h200);
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_row1_en", interface_en, 1);
        check("rst_row1_addr", interface_addr, 32'h204);
        #2 rst = 1'b1;
        #1 check_zero("midrst");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("postrst_done", done, 0);
            check("postrst_rd_valid", rd_valid, 0);
            check("postrst_busy", busy, 0);
            check("postrst_en", interface_en, 0);
            @(posedge clk); #1;
        end

        // A fresh transfer after the abandoned one completes normally.
        exp_addr[0] = 32'h300; exp_addr[1] = 32'h308;
        exp_row[0] = 128'h030201;
        exp_row[1] = 128'h0B0A09;
        run_read(32'h300, 32'h8, 8'd2, 5'd3, 5'd3, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
